slow_set_ctrl: RTL and testbench

Parametrised successor to the slow-peripheral settings register. A bus write to the settings chip-select latches a per-channel slow-enable mask and a timeout field from address lines, with one commit per bus cycle and a commit acknowledge. It also runs a prescaled slow-window timer: an access to any slow-enabled device loads the timer, and SlowActive stays asserted until the timer expires. Sits between the bus-cycle decoder and the accelerator clock/timing control.

---
 rtl/slow_set_ctrl.sv | 92 +++++++++
 tb/tb_slow_set_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/slow_set_ctrl.sv
// Slow-peripheral settings register: latches per-channel slow-enable mask and
// timeout from the address bus, and runs the prescaled slow-window timer.
module slow_set_ctrl #(
   parameter int unsigned    NCH    = 7,
   parameter int unsigned    TW     = 4,
   parameter int unsigned    PRE    = 16,
   parameter logic [NCH-1:0] EN_RST = '1,
   parameter logic [TW-1:0]  TO_RST = '1
) (
   input  logic              CLK,
   input  logic              nPOR,
   input  logic              BACT,
   input  logic [NCH+TW:1]   A,
   input  logic              SetCSWR,
   input  logic [NCH-1:0]    DevAcc,
   output logic [NCH-1:0]    SlowEn,
   output logic [TW-1:0]     SlowTimeout,
   output logic [TW-1:0]     SlowCnt,
   output logic              SlowActive,
   output logic              SetAck
);

   localparam int unsigned PW       = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

   logic             setwr_r_q, setwr_r_d;
   logic             setwr_d_q, setwr_d_d;
   logic [NCH-1:0]   en_q, en_d;
   logic [TW-1:0]    to_q, to_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic [PW-1:0]    pre_q, pre_d;

   logic             commit;
   logic             tick;
   logic             hit;
   logic [NCH-1:0]   wr_en;
   logic [TW-1:0]    wr_to;

   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         setwr_r_q <= 1'b0;
         setwr_d_q <= 1'b0;
         en_q      <= EN_RST;
         to_q      <= TO_RST;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         pre_q     <= '0;
      end else begin
         setwr_r_q <= setwr_r_d;
         setwr_d_q <= setwr_d_d;
         en_q      <= en_d;
         to_q      <= to_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         pre_q     <= pre_d;
      end
   end

   always_comb begin
      wr_en     = A[NCH:1];
      wr_to     = A[NCH+TW:NCH+1];
      setwr_r_d = BACT && SetCSWR;
      setwr_d_d = setwr_r_q;
      commit    = setwr_r_q && !setwr_d_q;
      tick      = (pre_q == PRE_LAST);
      pre_d     = tick ? '0 : pre_q + PW'(1);
      // hit and timer reload deliberately use the pre-commit mask/timeout
      hit       = |(DevAcc & en_q);
      en_d      = commit ? wr_en : en_q;
      to_d      = commit ? wr_to : to_q;
      ack_d     = commit;
      if (commit && (wr_en == '0)) begin
         cnt_d = '0;
      end else if (hit) begin
         cnt_d = to_q;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - TW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      SlowEn      = en_q;
      SlowTimeout = to_q;
      SlowCnt     = cnt_q;
      SlowActive  = (cnt_q != '0);
      SetAck      = ack_q;
   end

endmodule

// File: tb/tb_slow_set_ctrl.sv
// Directed bench for slow_set_ctrl with a cycle-level behavioural model and
// hand-computed literal checks at key points.
module tb_slow_set_ctrl;

   localparam int unsigned NCH = 7;
   localparam int unsigned TW  = 4;
   localparam int unsigned PRE = 4;

   logic              CLK = 1'b0;
   logic              nPOR;
   logic              BACT;
   logic [NCH+TW:1]   A;
   logic              SetCSWR;
   logic [NCH-1:0]    DevAcc;
   logic [NCH-1:0]    SlowEn;
   logic [TW-1:0]     SlowTimeout;
   logic [TW-1:0]     SlowCnt;
   logic              SlowActive;
   logic              SetAck;

   int total = 0;
   int bad   = 0;

   slow_set_ctrl #(.NCH(NCH), .TW(TW), .PRE(PRE)) dut (
      .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .A(A), .SetCSWR(SetCSWR),
      .DevAcc(DevAcc), .SlowEn(SlowEn), .SlowTimeout(SlowTimeout),
      .SlowCnt(SlowCnt), .SlowActive(SlowActive), .SetAck(SetAck)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: request history, cycle count since reset, plain counter.
   logic [NCH-1:0] m_en;
   logic [TW-1:0]  m_to;
   int             m_cnt;
   bit             m_ack;
   bit             req_prev1, req_prev2;
   int             cyc;
   bit             model_ok = 0;

   always @(posedge CLK) begin
      bit commit, hit, tick;
      if (!nPOR) begin
         m_en = '1; m_to = '1; m_cnt = 0; m_ack = 0;
         req_prev1 = 0; req_prev2 = 0; cyc = 0; model_ok = 1;
      end else begin
         commit = req_prev1 && !req_prev2;
         hit    = (DevAcc & m_en) != 0;
         tick   = (cyc % PRE) == (PRE - 1);
         if (commit && A[NCH:1] == 0)   m_cnt = 0;
         else if (hit)                  m_cnt = int'(m_to);
         else if (tick && m_cnt > 0)    m_cnt = m_cnt - 1;
         if (commit) begin
            m_en = A[NCH:1];
            m_to = A[NCH+TW:NCH+1];
         end
         m_ack     = commit;
         req_prev2 = req_prev1;
         req_prev1 = BACT && SetCSWR;
         cyc++;
      end
   end

   always @(negedge CLK) begin
      if (model_ok) begin
         chk("m_SlowEn",      32'(SlowEn),      32'(m_en));
         chk("m_SlowTimeout", 32'(SlowTimeout), 32'(m_to));
         chk("m_SlowCnt",     32'(SlowCnt),     32'(m_cnt));
         chk("m_SlowActive",  32'(SlowActive),  32'(m_cnt != 0));
         chk("m_SetAck",      32'(SetAck),      32'(m_ack));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic write(input logic [TW-1:0] to, input logic [NCH-1:0] en);
      A = {to, en}; BACT = 1'b1; SetCSWR = 1'b1;
      step(); step();
      BACT = 1'b0; SetCSWR = 1'b0;
      step();
   endtask

   task automatic wait_cnt(input int v, input string name);
      int n = 0;
      while (int'(SlowCnt) != v && n < 40) begin
         step();
         n++;
      end
      if (int'(SlowCnt) != v) chk(name, 32'(SlowCnt), 32'(v));
   endtask

   task automatic hit_once(input logic [NCH-1:0] d);
      DevAcc = d;
      step();
      DevAcc = '0;
   endtask

   initial begin
      int ack_n;
      int len;
      int prev;
      int seen[$];

      nPOR = 1'b0; BACT = 1'b0; SetCSWR = 1'b0; A = '0; DevAcc = '0;
      step(); step();
      chk("rst_SlowEn",      32'(SlowEn),      32'h7F);
      chk("rst_SlowTimeout", 32'(SlowTimeout), 32'hF);
      chk("rst_SlowCnt",     32'(SlowCnt),     32'h0);
      chk("rst_SlowActive",  32'(SlowActive),  32'h0);
      chk("rst_SetAck",      32'(SetAck),      32'h0);
      nPOR = 1'b1;
      step();

      // Held write: one commit, one ack
      A = {4'h3, 7'h05}; BACT = 1'b1; SetCSWR = 1'b1;
      ack_n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (SetAck) ack_n++;
         if (i == 1) begin
            chk("held_en_2edges", 32'(SlowEn),      32'h05);
            chk("held_to_2edges", 32'(SlowTimeout), 32'h3);
         end
      end
      BACT = 1'b0; SetCSWR = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (SetAck) ack_n++;
      end
      chk("held_ack_count", 32'(ack_n), 32'd1);

      // Window: EN=01, TO=3
      write(4'h3, 7'h01);
      hit_once(7'h01);
      chk("win_load", 32'(SlowCnt), 32'd3);
      len = 1; prev = 3; seen.delete();
      for (int i = 0; i < 40 && SlowCnt != 0; i++) begin
         step();
         if (SlowActive) len++;
         if (int'(SlowCnt) != prev) begin
            seen.push_back(int'(SlowCnt));
            prev = int'(SlowCnt);
         end
      end
      chk("win_seq_len", 32'(seen.size()), 32'd3);
      if (seen.size() == 3) begin
         chk("win_seq_0", 32'(seen[0]), 32'd2);
         chk("win_seq_1", 32'(seen[1]), 32'd1);
         chk("win_seq_2", 32'(seen[2]), 32'd0);
      end
      chk("win_len_range", 32'(len >= 9 && len <= 12), 32'd1);

      hit_once(7'h02);
      chk("disabled_no_load", 32'(SlowCnt), 32'd0);

      // Re-arm: hit at the tick edge where count is 1
      hit_once(7'h01);
      wait_cnt(1, "rearm_wait1");
      for (int i = 0; i < int'(PRE) - 1; i++) step();
      chk("rearm_pre", 32'(SlowCnt), 32'd1);
      hit_once(7'h01);
      chk("rearm_reload", 32'(SlowCnt), 32'd3);

      // Commit of all-zero mask during count 2
      wait_cnt(2, "zero_wait2");
      A = {4'h3, 7'h00}; BACT = 1'b1; SetCSWR = 1'b1;
      step();
      chk("zero_before", 32'(SlowCnt), 32'd2);
      step();
      chk("zero_forced", 32'(SlowCnt), 32'd0);
      chk("zero_en", 32'(SlowEn), 32'd0);
      BACT = 1'b0; SetCSWR = 1'b0;
      step();

      // Commit + hit at the same edge uses the old timeout
      write(4'h5, 7'h01);
      A = {4'h1, 7'h01}; BACT = 1'b1; SetCSWR = 1'b1;
      step();
      DevAcc = 7'h01;
      step();
      DevAcc = '0; BACT = 1'b0; SetCSWR = 1'b0;
      chk("cmh_cnt", 32'(SlowCnt), 32'd5);
      chk("cmh_to",  32'(SlowTimeout), 32'd1);
      step();

      // Reset mid-window and mid-write
      write(4'h3, 7'h7F);
      hit_once(7'h10);
      wait_cnt(2, "rst_wait2");
      A = {4'h2, 7'h11}; BACT = 1'b1; SetCSWR = 1'b1;
      step();
      nPOR = 1'b0;
      step();
      chk("mid_rst_en",  32'(SlowEn),      32'h7F);
      chk("mid_rst_to",  32'(SlowTimeout), 32'hF);
      chk("mid_rst_cnt", 32'(SlowCnt),     32'h0);
      chk("mid_rst_act", 32'(SlowActive),  32'h0);
      chk("mid_rst_ack", 32'(SetAck),      32'h0);
      BACT = 1'b0; SetCSWR = 1'b0; nPOR = 1'b1;
      ack_n = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (SetAck) ack_n++;
      end
      chk("post_rst_no_ack", 32'(ack_n), 32'd0);
      chk("post_rst_en", 32'(SlowEn), 32'h7F);

      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
